// File: rtl/tone_freq_meter.sv
// Tone frequency meter: counts synchronised rising edges of tone_in over a
// fixed window of GATE_CYCLES in_clk cycles and reports the count. Windows
// follow each other back to back with no dead cycle.
module tone_freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        in_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        tone_in,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        tone_present
);

    // gate_cnt only has to reach GATE_CYCLES-1, so clog2 of the window is enough
    localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_GATE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [GW-1:0]          gate_q, gate_d;
    logic [31:0]            edge_q, edge_d;
    logic [31:0]            freq_q, freq_d;
    logic                   valid_q, valid_d;
    logic                   present_q, present_d;
    logic                   rise_s;
    logic [31:0]            edge_sum_s;

    // Synchroniser shift and one-cycle edge history; runs in every state
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], tone_in};
        prev_d     = sync_q[SYNC_STAGES-1];
        rise_s     = sync_q[SYNC_STAGES-1] & ~prev_q;
        edge_sum_s = edge_q + {31'd0, rise_s};
    end

    // Gate FSM: window counting, result capture on the last window cycle, abort
    always_comb begin
        state_d   = state_q;
        gate_d    = gate_q;
        edge_d    = edge_q;
        freq_d    = freq_q;
        valid_d   = 1'b0;
        present_d = present_q;
        case (state_q)
            ST_IDLE: begin
                gate_d = '0;
                edge_d = 32'd0;
                if (enable) begin
                    state_d = ST_GATE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (gate_q == GATE_LAST) begin
                    // An edge seen on the last window cycle still belongs to it
                    freq_d    = edge_sum_s;
                    present_d = (edge_sum_s != 32'd0);
                    valid_d   = 1'b1;
                    gate_d    = '0;
                    edge_d    = 32'd0;
                    if (enable) begin
                        state_d = ST_GATE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!enable) begin
                    // Abort: drop the partial count, keep the last result
                    state_d = ST_IDLE;
                    gate_d  = '0;
                    edge_d  = 32'd0;
                end else begin
                    state_d = ST_GATE;
                    gate_d  = gate_q + GW'(1);
                    edge_d  = edge_sum_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gate_d  = '0;
                edge_d  = 32'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            gate_q    <= '0;
            edge_q    <= 32'd0;
            freq_q    <= 32'd0;
            valid_q   <= 1'b0;
            present_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            gate_q    <= gate_d;
            edge_q    <= edge_d;
            freq_q    <= freq_d;
            valid_q   <= valid_d;
            present_q <= present_d;
        end
    end

    assign freq_out     = freq_q;
    assign freq_valid   = valid_q;
    assign tone_present = present_q;

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed bench for tone_freq_meter with a 1000-cycle window.
module tb_tone_freq_meter;

    localparam int GATE = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        tone_in;
    logic [31:0] freq_out;
    logic        freq_valid;
    logic        tone_present;

    int n_checks = 0;
    int n_fail   = 0;

    // tone control: half-period in cycles (0 = hold tone_level)
    int tone_half  = 10;
    bit tone_level = 1'b0;

    typedef struct {
        int half;
        bit level;
        int skip;
        int nwin;
        int fmin;
        int fmax;
        int pres;
    } vec_t;

    vec_t tbl[5];

    tone_freq_meter #(.GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut (
        .in_clk      (clk),
        .reset       (reset),
        .enable      (enable),
        .tone_in     (tone_in),
        .freq_out    (freq_out),
        .freq_valid  (freq_valid),
        .tone_present(tone_present)
    );

    // 100 MHz-style clock
    always #5 clk = ~clk;

    // Tone generator, updating shortly after each rising clock edge
    initial begin
        int tcnt;
        tcnt    = 0;
        tone_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tone_half == 0) begin
                tone_in = tone_level;
                tcnt    = 0;
            end else begin
                tcnt++;
                if (tcnt >= tone_half) begin
                    tcnt    = 0;
                    tone_in = ~tone_in;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Wait for the next freq_valid (bounded), check its distance and width
    task automatic next_pulse(input int exp_dist, input string name,
                              output int f, output int p);
        int d;
        bit found;
        d     = 0;
        found = 1'b0;
        while (!found && d < 2500) begin
            @(negedge clk);
            d++;
            if (freq_valid) found = 1'b1;
        end
        f = int'(freq_out);
        p = int'(tone_present);
        chk({name, " pulse distance"}, found ? d : -1, exp_dist);
        @(negedge clk);
        chk({name, " pulse width"}, int'(freq_valid), 0);
    endtask

    initial begin
        int f;
        int p;
        int hits;
        int exp_dist;

        tbl[0] = '{half: 10, level: 1'b0, skip: 0, nwin: 3, fmin: 50,  fmax: 50,  pres: 1};
        tbl[1] = '{half: 1,  level: 1'b0, skip: 1, nwin: 2, fmin: 500, fmax: 500, pres: 1};
        tbl[2] = '{half: 19, level: 1'b0, skip: 1, nwin: 2, fmin: 26,  fmax: 27,  pres: 1};
        tbl[3] = '{half: 10, level: 1'b0, skip: 1, nwin: 1, fmin: 50,  fmax: 50,  pres: 1};
        tbl[4] = '{half: 0,  level: 1'b1, skip: 1, nwin: 1, fmin: 0,   fmax: 0,   pres: 0};

        // Reset
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset freq_out", int'(freq_out), 0);
        chk("reset freq_valid", int'(freq_valid), 0);
        chk("reset tone_present", int'(tone_present), 0);
        reset = 1'b0;

        // Disabled with a running tone: nothing must happen
        hits = 0;
        repeat (3000) begin
            @(negedge clk);
            if (freq_valid) hits++;
        end
        chk("idle valid count", hits, 0);
        chk("idle freq_out", int'(freq_out), 0);
        chk("idle tone_present", int'(tone_present), 0);

        // Continuous measurement over the vector table
        enable   = 1'b1;
        exp_dist = GATE + 1;
        for (int v = 0; v < 5; v++) begin
            tone_half  = tbl[v].half;
            tone_level = tbl[v].level;
            for (int w = 0; w < tbl[v].skip + tbl[v].nwin; w++) begin
                next_pulse(exp_dist, $sformatf("vec%0d win%0d", v, w), f, p);
                exp_dist = GATE - 1;
                if (w >= tbl[v].skip) begin
                    chk_range($sformatf("vec%0d win%0d freq_out", v, w), f, tbl[v].fmin, tbl[v].fmax);
                    chk($sformatf("vec%0d win%0d tone_present", v, w), p, tbl[v].pres);
                end
            end
        end

        // Back to period 20 to get a 50 result before the abort
        tone_half = 10;
        next_pulse(GATE - 1, "rearm settle", f, p);
        next_pulse(GATE - 1, "pre-abort", f, p);
        chk("pre-abort freq_out", f, 50);

        // Abort mid-window (enable sampled low at gate_cnt=500)
        repeat (499) @(negedge clk);
        enable = 1'b0;
        hits = 0;
        repeat (1500) begin
            @(negedge clk);
            if (freq_valid) hits++;
        end
        chk("abort valid count", hits, 0);
        chk("abort freq_out hold", int'(freq_out), 50);
        chk("abort tone_present hold", int'(tone_present), 1);

        // Re-arm: full fresh window
        enable = 1'b1;
        next_pulse(GATE + 1, "rearm", f, p);
        chk("rearm freq_out", f, 50);
        chk("rearm tone_present", p, 1);

        // Reset for one cycle at gate_cnt=700 with enable held high
        repeat (699) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset freq_out", int'(freq_out), 0);
        chk("midreset tone_present", int'(tone_present), 0);
        chk("midreset freq_valid", int'(freq_valid), 0);
        reset = 1'b0;
        next_pulse(GATE + 1, "post-reset", f, p);
        chk("post-reset freq_out", f, 50);
        chk("post-reset tone_present", p, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_freq_meter.md
Name: tone_freq_meter

Overview:
- Measures the frequency of an incoming square-wave tone and reports it as an integer count.
- It is the reverse of the tone organ's clock divider: the divider turns a frequency word into a tone, and this block turns a tone back into a frequency word.
- With the default 1 s gate, freq_out is in Hz, in the same units as the divider's freq_in. This allows loopback self-test of the organ and pitch display.
- Gate-counting method: rising edges of the synchronised tone are counted over a fixed window of in_clk cycles, and the window restarts with no dead time.

Parameters:
- GATE_CYCLES, 50_000_000, in_clk cycles per measurement window (1 s at 50 MHz); must be ≥ 2.
- SYNC_STAGES, 2, flip-flop stages synchronising tone_in to in_clk; must be ≥ 2.

Ports:
- in_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = measure continuously; 0 = idle or abort the current window.
- tone_in  input  1  asynchronous square-wave tone under measurement.
- freq_out  output  32  rising-edge count of the last completed window.
- freq_valid  output  1  one-cycle pulse, coincident with each freq_out update.
- tone_present  output  1  registered (freq_out != 0).

Behaviour:
- Reset (synchronous, active-high; wins over every other input in the same cycle):
  - Clears the sync chain, the edge-detect history, gate_cnt and edge_cnt.
  - freq_out=0, freq_valid=0, tone_present=0; state=IDLE.
- Synchronisation and edge detection:
  - The SYNC_STAGES chain runs every cycle in every state.
  - rise = last sync stage AND NOT previous-cycle last stage.
  - A tone_in rising edge yields rise SYNC_STAGES+1 cycles later.
  - Maximum measurable rate: one rising edge per 2 in_clk cycles.
- FSM states: IDLE, GATE.
  - IDLE: counters held at 0; rise ignored. enable=1 sampled at cycle N → GATE at N+1 with gate_cnt=0, edge_cnt=0.
  - GATE, each cycle: gate_cnt += 1; edge_cnt += rise.
  - GATE, last cycle (gate_cnt == GATE_CYCLES-1), registered updates:
    - freq_out <= edge_cnt + rise (an edge on the last cycle is counted);
    - tone_present <= (edge_cnt + rise != 0);
    - freq_valid <= 1;
    - gate_cnt, edge_cnt <= 0;
    - next state GATE if enable=1, else IDLE.
    - The next window starts on the following cycle with no dead cycle.
  - GATE, enable=0 on any cycle other than the last: abort to IDLE, clear counters, no freq_valid. freq_out and tone_present hold.
- Timing:
  - Window length is exactly GATE_CYCLES cycles.
  - The first freq_valid comes GATE_CYCLES+1 cycles after the enable sample at N, i.e. cycle N+GATE_CYCLES+1.
  - Later pulses repeat every GATE_CYCLES cycles.
  - freq_valid is high for exactly 1 cycle, otherwise 0.
- Widths: gate_cnt is wide enough for GATE_CYCLES-1; edge_cnt and freq_out are 32-bit, never saturate (max GATE_CYCLES/2).
- Tone stuck high or low: windows still complete; freq_out=0, tone_present=0, freq_valid still pulses.
- Period not dividing GATE_CYCLES: the result is floor or ceil of GATE_CYCLES/period, depending on phase.

Test Plan:
- Reset, then enable=0 for 3000 cycles with tone toggling every 10 cycles → freq_out=0, tone_present=0, freq_valid never asserted.
- GATE_CYCLES=1000, tone period 20 cycles, enable raised at cycle N:
  - freq_valid pulses exactly at N+1001, N+2001, N+3001;
  - each pulse shows freq_out=50, tone_present=1;
  - the pulse is 1 cycle wide.
- GATE_CYCLES=1000, tone period 2 (toggle every cycle) → freq_out=500 on every window. Then change to period 38 → after one transitional window, freq_out ∈ {26,27} each window.
- After a freq_out=50 result, hold tone_in at 1 → next full window gives freq_out=0, tone_present=0, freq_valid still pulses on schedule.
- Abort and re-arm:
  - Drop enable at gate_cnt=500 → no freq_valid, freq_out stays 50.
  - Re-raise enable at cycle M → first pulse at M+1001 with freq_out=50 (no stale partial count).
- Assert reset for 1 cycle at gate_cnt=700 with enable held 1:
  - Next cycle freq_out=0, tone_present=0, state IDLE.
  - First post-reset freq_valid comes 1001 cycles after the first enable sample following reset, with freq_out=50.
